// File: rtl/serial_tc_negate.sv
// Bit-serial two's-complement negator, LSB first.
// Each word is either passed through or negated according to the mode
// captured with its bit 0. Negation uses the classic serial rule: copy
// bits up to and including the first 1, then invert every later bit.
// All outputs are registered one cycle behind the accepted input bit.
module serial_tc_negate #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic in_valid,
    input  logic in_bit,
    input  logic neg,
    output logic out_valid,
    output logic out_bit,
    output logic out_last,
    output logic ovf,
    output logic ovf_sticky
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        SEEK   = 1'b0,
        INVERT = 1'b1
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          mode_reg, mode_next;
    logic          sticky_next;
    logic          out_bit_next;
    logic          out_last_next;
    logic          ovf_next;

    // Bit-position and per-word context seen by the current input bit.
    // A start pulse makes this bit bit 0 regardless of the counter.
    logic   is_first;
    logic   is_last;
    logic   mode_eff;
    state_t state_eff;
    logic   result;

    // Decode the current bit: bit 0 re-evaluates in SEEK with a fresh mode.
    always_comb begin
        is_first  = start || (cnt_reg == '0);
        is_last   = !start && (cnt_reg == LAST_IDX);
        mode_eff  = is_first ? neg : mode_reg;
        state_eff = is_first ? SEEK : state_reg;
        result    = (mode_eff && (state_eff == INVERT)) ? ~in_bit : in_bit;
    end

    // Next-state and next-output logic; idle cycles hold all word state.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        mode_next     = mode_reg;
        out_bit_next  = 1'b0;
        out_last_next = 1'b0;
        ovf_next      = 1'b0;
        sticky_next   = ovf_sticky;

        if (in_valid) begin
            mode_next = mode_eff;
            if (state_eff == SEEK && in_bit) begin
                state_next = INVERT;
            end else begin
                state_next = state_eff;
            end
            if (start) begin
                cnt_next = CW'(1);
            end else if (cnt_reg == LAST_IDX) begin
                cnt_next = '0;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
            out_bit_next  = result;
            out_last_next = is_last;
            // Input 100...0 negates to itself: the most negative value.
            ovf_next      = is_last && mode_eff && (state_eff == SEEK) && in_bit;
        end else if (start) begin
            cnt_next = '0;
        end

        // A fresh overflow outranks a clearing start on the same edge.
        if (ovf_next) begin
            sticky_next = 1'b1;
        end else if (start) begin
            sticky_next = 1'b0;
        end
    end

    // FSM state, bit counter and latched word mode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= SEEK;
            cnt_reg   <= '0;
            mode_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            mode_reg  <= mode_next;
        end
    end

    // Registered outputs, one cycle behind the accepted bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_bit    <= 1'b0;
            out_last   <= 1'b0;
            ovf        <= 1'b0;
            ovf_sticky <= 1'b0;
        end else begin
            out_valid  <= in_valid;
            out_bit    <= out_bit_next;
            out_last   <= out_last_next;
            ovf        <= ovf_next;
            ovf_sticky <= sticky_next;
        end
    end

endmodule

// File: tb/tb_serial_tc_negate.sv
// Scoreboard bench for serial_tc_negate (WIDTH = 8): stimulus pushes
// hand-computed expected output bits, a negedge monitor pops and compares.
module tb_serial_tc_negate;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic in_bit = 1'b0;
    logic neg = 1'b0;
    logic out_valid, out_bit, out_last, ovf, ovf_sticky;

    int total = 0;
    int bad = 0;

    // expected {bit, last, ovf} per output bit
    logic [2:0] sb_q[$];
    logic       exp_ov;

    serial_tc_negate #(.WIDTH(8)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .in_valid(in_valid),
        .in_bit(in_bit),
        .neg(neg),
        .out_valid(out_valid),
        .out_bit(out_bit),
        .out_last(out_last),
        .ovf(ovf),
        .ovf_sticky(ovf_sticky)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // out_valid must mirror in_valid one cycle later
    always @(posedge clk or posedge reset) begin
        if (reset) exp_ov <= 1'b0;
        else       exp_ov <= in_valid;
    end

    // Monitor: compare every presented output bit against the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            check("out_valid", {7'b0, out_valid}, {7'b0, exp_ov});
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_output", 8'd1, 8'd0);
                end else begin
                    logic [2:0] e;
                    e = sb_q.pop_front();
                    check("out_bit", {7'b0, out_bit}, {7'b0, e[2]});
                    check("out_last", {7'b0, out_last}, {7'b0, e[1]});
                    check("ovf", {7'b0, ovf}, {7'b0, e[0]});
                    $display("out bit=%0b last=%0b ovf=%0b sticky=%0b", out_bit, out_last, ovf, ovf_sticky);
                end
            end else begin
                check("idle_zero", {5'b0, out_bit, out_last, ovf}, 8'd0);
            end
        end
    end

    // Drive n bits of din (LSB first); expected bits come from dout.
    task automatic send_bits(input logic [7:0] din, input logic neg_v, input logic [7:0] dout,
                             input logic ovf_v, input int n, input logic gap, input logic st);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_bit   = din[i];
            neg      = neg_v;
            start    = st && (i == 0);
            sb_q.push_back({dout[i], (n == 8) && (i == 7), ovf_v && (i == 7)});
            @(posedge clk); #1;
            start = 1'b0;
            if (gap) begin
                in_valid = 1'b0;
                in_bit   = 1'b0;
                @(posedge clk); #1;
            end
        end
        $display("sent din=%02h neg=%0b n=%0d exp=%02h", din, neg_v, n, dout);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_bit   = 1'b0;
        neg      = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {3'b0, out_valid, out_bit, out_last, ovf, ovf_sticky}, 8'd0);
        reset = 1'b0;
        idle(1);

        // negate 6 -> -6
        send_bits(8'h06, 1'b1, 8'hFA, 1'b0, 8, 1'b0, 1'b0);
        check("sticky_after_06", {7'b0, ovf_sticky}, 8'd0);
        // most negative value overflows
        send_bits(8'h80, 1'b1, 8'h80, 1'b1, 8, 1'b0, 1'b0);
        check("sticky_after_80", {7'b0, ovf_sticky}, 8'd1);
        // negate zero, sticky holds
        send_bits(8'h00, 1'b1, 8'h00, 1'b0, 8, 1'b0, 1'b0);
        check("sticky_holds", {7'b0, ovf_sticky}, 8'd1);
        // back-to-back, mode changes at word boundary
        send_bits(8'h5A, 1'b0, 8'h5A, 1'b0, 8, 1'b0, 1'b0);
        send_bits(8'h01, 1'b1, 8'hFF, 1'b0, 8, 1'b0, 1'b0);
        idle(2);
        // alternating in_valid gaps
        send_bits(8'h06, 1'b1, 8'hFA, 1'b0, 8, 1'b1, 1'b0);
        idle(1);

        // reset mid-word abandons the partial word
        send_bits(8'h07, 1'b1, 8'h01, 1'b0, 3, 1'b0, 1'b0);
        in_valid = 1'b0;
        in_bit   = 1'b0;
        @(negedge clk); #1;
        reset = 1'b1;
        #1;
        check("async_reset_clears", {3'b0, out_valid, out_bit, out_last, ovf, ovf_sticky}, 8'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        idle(1);
        // first bit after reset is bit 0
        send_bits(8'h80, 1'b1, 8'h80, 1'b1, 8, 1'b0, 1'b0);
        check("sticky_set_again", {7'b0, ovf_sticky}, 8'd1);
        // partial word then idle start pulse realigns and clears sticky
        send_bits(8'h04, 1'b1, 8'h1C, 1'b0, 5, 1'b0, 1'b0);
        in_valid = 1'b0;
        in_bit   = 1'b0;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_clears_sticky", {7'b0, ovf_sticky}, 8'd0);
        send_bits(8'h03, 1'b1, 8'hFD, 1'b0, 8, 1'b0, 1'b0);
        // start together with in_valid: this bit is bit 0
        send_bits(8'h05, 1'b0, 8'h05, 1'b0, 3, 1'b0, 1'b0);
        send_bits(8'h06, 1'b1, 8'hFA, 1'b0, 8, 1'b0, 1'b1);
        send_bits(8'h80, 1'b1, 8'h80, 1'b1, 8, 1'b0, 1'b0);
        idle(1);

        // drain with a bound
        for (int t = 0; t < 50 && sb_q.size() != 0; t++) begin
            @(posedge clk); #1;
        end
        check("scoreboard_empty", 8'(sb_q.size()), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
